golomb_rice_exp_encoder: RTL and testbench
==========================================

Name: golomb_rice_exp_encoder

Overview:
Parametrised, pipelined successor to the single-mode Golomb-Rice length/codeword unit. It encodes one magnitude per cycle with an adaptive hybrid code: Rice below a switch point, exp-Golomb above it, plus an optional AC sign bit. It uses a valid/ready handshake with full back-pressure, flags codewords that overflow the output width, and keeps a running coded-bit total. It sits between the AC/DC level/run scanner and the bit packer in the entropy encode path.

Parameters:
VAL_W, 32, magnitude width.
K_W, 3, width of rice_k and exp_k.
LQ_W, 3, width of last_rice_q.
CODE_W, 64, codeword output width; the maximum legal length including the sign bit.
LEN_W, 7, length field width; must satisfy 2^LEN_W > CODE_W.
CNT_W, 32, width of the total-bits accumulator.

Ports:
clk  in  1  clock, all state on the rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  encoder can accept an input word
val  in  VAL_W  magnitude to encode
rice_k  in  K_W  Rice parameter
exp_k  in  K_W  exp-Golomb order
last_rice_q  in  LQ_W  largest quotient still coded as Rice
is_ac  in  1  append sign bit
is_minus_n  in  1  sign bit value appended when is_ac=1
out_valid  out  1  codeword valid
out_ready  in  1  downstream accepts the codeword
code_bits  out  CODE_W  codeword, right-aligned; leading zeros are implicit
code_len  out  LEN_W  codeword length in bits
overflow  out  1  codeword length exceeded CODE_W
clr_total  in  1  synchronous clear of total_bits
total_bits  out  CNT_W  sum of code_len over accepted outputs

Behaviour:
- Reset (async, reset_n=0): all stage valids=0, out_valid=0, code_bits=0, code_len=0, overflow=0, total_bits=0. in_ready becomes 1 after reset. Reset mid-stream discards all in-flight words.
- Pipeline: 3 stages with one global enable, en = out_ready | ~out_valid.
  - in_ready = en.
  - Input accepted when in_valid & in_ready.
  - Every stage advances only when en=1. Bubbles advance and do not collapse.
  - Latency is 3 cycles from acceptance to out_valid when out_ready is held at 1. Throughput is 1 word/cycle.
- While out_valid=1 and out_ready=0, all outputs hold stable and nothing is lost or duplicated. Output order equals input order.
- S1 registers the inputs and computes the following (all arithmetic in VAL_W+2 bits, no truncation):
  - q = val >> rice_k
  - sw = (last_rice_q+1) << rice_k
  - mode = Rice if q <= last_rice_q, else Exp
  - w = val - sw + (1<<exp_k)
- S2 computes n = index of the most-significant 1 in w (Exp mode only; w >= 1 is guaranteed).
- S3 assembles the codeword:
  - Rice: base = (1<<rice_k) | (val & ((1<<rice_k)-1)); len = q + 1 + rice_k. With rice_k=0: base=1, len=q+1.
  - Exp: base = w; len = (last_rice_q+1) + 2n - exp_k + 1.
  - If is_ac=1: bits = (base<<1) | is_minus_n and len += 1. Otherwise bits = base.
  - If len > CODE_W: overflow=1, code_len=CODE_W, code_bits=0. Otherwise overflow=0.
- total_bits adds code_len on every out_valid & out_ready handshake. It wraps modulo 2^CNT_W.
  - clr_total=1 sets total_bits to 0.
  - If clr_total=1 coincides with a handshake in the same cycle, total_bits = code_len of that word (clear first, then add).
- Inputs are sampled only on acceptance. Values while in_ready=0 are ignored.

Test Plan:
1. val=2, rice_k=0, last_rice_q=3, is_ac=0 -> Rice; code_bits=1, code_len=3, overflow=0, 3 cycles after acceptance.
2. val=6, rice_k=2, last_rice_q=4, is_ac=1, is_minus_n=1 -> q=1; code_bits=13, code_len=5.
3. val=5, rice_k=0, last_rice_q=1, exp_k=0, is_ac=0 -> Exp; w=4, n=2; code_bits=4, code_len=7 (bit string 0000100).
4. Stream vals 0..4 (rice_k=0, last_rice_q=7, is_ac=0) with out_ready=0 for 4 cycles mid-stream -> in_ready drops, outputs hold; code_len sequence 1,2,3,4,5 exactly once each, in order; total_bits=15.
5. val=2^32-1, rice_k=0, last_rice_q=7, exp_k=0, is_ac=1 -> overflow=1, code_len=64, code_bits=0. The next word (val=0) encodes normally with code_len=2.
6. Assert reset_n=0 with 3 words in flight, then release -> no output from the flushed words, total_bits=0. Then apply clr_total together with a handshake of code_len=3 -> total_bits=3.

Source files
------------

// File: rtl/golomb_rice_exp_encoder.sv
// Three-stage hybrid Rice / exp-Golomb codeword encoder with valid/ready back-pressure,
// output-width overflow flagging and a running total of emitted code bits.
module golomb_rice_exp_encoder #(
    parameter int VAL_W  = 32,
    parameter int K_W    = 3,
    parameter int LQ_W   = 3,
    parameter int CODE_W = 64,
    parameter int LEN_W  = 7,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VAL_W-1:0]  val,
    input  logic [K_W-1:0]    rice_k,
    input  logic [K_W-1:0]    exp_k,
    input  logic [LQ_W-1:0]   last_rice_q,
    input  logic              is_ac,
    input  logic              is_minus_n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code_bits,
    output logic [LEN_W-1:0]  code_len,
    output logic              overflow,
    input  logic              clr_total,
    output logic [CNT_W-1:0]  total_bits
);

    localparam int AW  = VAL_W + 2;
    localparam int N_W = $clog2(AW + 1);
    localparam logic [AW-1:0] ONE_A = AW'(1);

    typedef enum logic {
        MODE_RICE,
        MODE_EXP
    } mode_e;

    typedef struct packed {
        logic              valid;
        logic [VAL_W-1:0]  val;
        logic [K_W-1:0]    rice_k;
        logic [K_W-1:0]    exp_k;
        logic [LQ_W-1:0]   lq;
        logic              ac;
        logic              neg;
        mode_e             mode;
        logic [AW-1:0]     q;
        logic [AW-1:0]     w;
    } s1_t;

    typedef struct packed {
        s1_t            s;
        logic [N_W-1:0] n;
    } s2_t;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;

    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] code_bits_q, code_bits_d;
    logic [LEN_W-1:0]  code_len_q, code_len_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  total_q, total_d;

    logic en;

    // One global enable: a bubble in the output stage lets the whole pipe move.
    assign en        = out_ready | ~out_valid_q;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign code_bits = code_bits_q;
    assign code_len  = code_len_q;
    assign overflow  = overflow_q;
    assign total_bits = total_q;

    // Stage 1: quotient, switch point, mode and exp-Golomb offset value
    logic [AW-1:0] val_x, lq_x, q_c, sw_c, w_c;
    mode_e         mode_c;

    always_comb begin
        val_x  = AW'(val);
        lq_x   = AW'(last_rice_q);
        q_c    = val_x >> rice_k;
        sw_c   = (lq_x + ONE_A) << rice_k;
        w_c    = val_x - sw_c + (ONE_A << exp_k);
        mode_c = (q_c <= lq_x) ? MODE_RICE : MODE_EXP;
        s1_d   = s1_q;
        if (en) begin
            s1_d.valid = in_valid;
            if (in_valid) begin
                s1_d.val    = val;
                s1_d.rice_k = rice_k;
                s1_d.exp_k  = exp_k;
                s1_d.lq     = last_rice_q;
                s1_d.ac     = is_ac;
                s1_d.neg    = is_minus_n;
                s1_d.mode   = mode_c;
                s1_d.q      = q_c;
                s1_d.w      = w_c;
            end
        end
    end

    // Stage 2: position of the leading one of w
    logic [N_W-1:0] n_c;

    always_comb begin
        n_c = '0;
        for (int unsigned i = 0; i < AW; i++) begin
            if (s1_q.w[i]) begin
                n_c = N_W'(i);
            end
        end
        s2_d = s2_q;
        if (en) begin
            s2_d.s = s1_q;
            s2_d.n = n_c;
        end
    end

    // Stage 3: codeword assembly, sign append and overflow substitution
    logic [AW-1:0] base_c, len_c, kmask_c;
    logic [AW:0]   bits_sgn_c, len_tot_c;
    logic          ovf_c;

    always_comb begin
        kmask_c = (ONE_A << s2_q.s.rice_k) - ONE_A;
        if (s2_q.s.mode == MODE_RICE) begin
            base_c = (ONE_A << s2_q.s.rice_k) | (AW'(s2_q.s.val) & kmask_c);
            len_c  = s2_q.s.q + ONE_A + AW'(s2_q.s.rice_k);
        end else begin
            base_c = s2_q.s.w;
            len_c  = AW'(s2_q.s.lq) + ONE_A + (AW'(s2_q.n) << 1) + ONE_A - AW'(s2_q.s.exp_k);
        end
        if (s2_q.s.ac) begin
            bits_sgn_c = {base_c, s2_q.s.neg};
        end else begin
            bits_sgn_c = {1'b0, base_c};
        end
        len_tot_c = {1'b0, len_c} + {{AW{1'b0}}, s2_q.s.ac};
        ovf_c     = len_tot_c > (AW + 1)'(CODE_W);

        out_valid_d = out_valid_q;
        code_bits_d = code_bits_q;
        code_len_d  = code_len_q;
        overflow_d  = overflow_q;
        if (en) begin
            out_valid_d = s2_q.s.valid;
            if (s2_q.s.valid) begin
                code_bits_d = ovf_c ? '0 : CODE_W'(bits_sgn_c);
                code_len_d  = ovf_c ? LEN_W'(CODE_W) : LEN_W'(len_tot_c);
                overflow_d  = ovf_c;
            end
        end
    end

    // Clear takes effect before a same-cycle handshake adds its length
    always_comb begin
        total_d = clr_total ? '0 : total_q;
        if (out_valid_q && out_ready) begin
            total_d = total_d + CNT_W'(code_len_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            code_bits_q <= '0;
            code_len_q  <= '0;
            overflow_q  <= 1'b0;
            total_q     <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            code_bits_q <= code_bits_d;
            code_len_q  <= code_len_d;
            overflow_q  <= overflow_d;
            total_q     <= total_d;
        end
    end

endmodule

// File: tb/tb_golomb_rice_exp_encoder.sv
// Scoreboard bench for golomb_rice_exp_encoder: directed scenarios plus a random
// stream under random back-pressure, each expected codeword from an arithmetic model.
module tb_golomb_rice_exp_encoder;

    localparam int VAL_W  = 32;
    localparam int K_W    = 3;
    localparam int LQ_W   = 3;
    localparam int CODE_W = 64;
    localparam int LEN_W  = 7;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [VAL_W-1:0]  val;
    logic [K_W-1:0]    rice_k;
    logic [K_W-1:0]    exp_k;
    logic [LQ_W-1:0]   last_rice_q;
    logic              is_ac;
    logic              is_minus_n;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] code_bits;
    logic [LEN_W-1:0]  code_len;
    logic              overflow;
    logic              clr_total;
    logic [CNT_W-1:0]  total_bits;

    golomb_rice_exp_encoder #(
        .VAL_W(VAL_W), .K_W(K_W), .LQ_W(LQ_W),
        .CODE_W(CODE_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .val(val), .rice_k(rice_k), .exp_k(exp_k), .last_rice_q(last_rice_q),
        .is_ac(is_ac), .is_minus_n(is_minus_n),
        .out_valid(out_valid), .out_ready(out_ready),
        .code_bits(code_bits), .code_len(code_len), .overflow(overflow),
        .clr_total(clr_total), .total_bits(total_bits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CODE_W-1:0] bits;
        logic [LEN_W-1:0]  len;
        logic              ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t model(input logic [VAL_W-1:0] v, input int unsigned rk,
                                   input int unsigned ek, input int unsigned lq,
                                   input logic ac, input logic neg);
        exp_t e;
        longint unsigned vl, q, sw, w, base, l;
        int unsigned n;
        vl = 64'(v);
        q  = vl >> rk;
        sw = 64'(lq + 1) << rk;
        if (q <= 64'(lq)) begin
            base = (64'd1 << rk) | (vl & ((64'd1 << rk) - 64'd1));
            l    = q + 64'd1 + 64'(rk);
        end else begin
            w = vl - sw + (64'd1 << ek);
            n = 0;
            for (int i = 0; i < 64; i++) if (w[i]) n = unsigned'(i);
            l    = 64'(lq) + 64'd1 + 64'(2 * n) - 64'(ek) + 64'd1;
            base = w;
        end
        if (ac) begin
            base = (base << 1) | 64'(neg);
            l    = l + 64'd1;
        end
        if (l > 64'(CODE_W)) begin
            e.ovf = 1'b1; e.len = LEN_W'(CODE_W); e.bits = '0;
        end else begin
            e.ovf = 1'b0; e.len = LEN_W'(l); e.bits = CODE_W'(base);
        end
        return e;
    endfunction

    // Output monitor: every handshake pops one expected word
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_output: got len=%0d bits=%h, expected no word", code_len, code_bits);
            end else begin
                mon_e = sb.pop_front();
                vectors++;
                if (code_bits !== mon_e.bits) begin
                    miscompares++;
                    $display("FAIL code_bits: got %h expected %h", code_bits, mon_e.bits);
                end
                vectors++;
                if (code_len !== mon_e.len) begin
                    miscompares++;
                    $display("FAIL code_len: got %0d expected %0d", code_len, mon_e.len);
                end
                vectors++;
                if (overflow !== mon_e.ovf) begin
                    miscompares++;
                    $display("FAIL overflow: got %b expected %b", overflow, mon_e.ovf);
                end
            end
        end
    end

    task automatic send(input logic [VAL_W-1:0] v, input int unsigned rk, input int unsigned ek,
                        input int unsigned lq, input logic ac, input logic neg);
        bit acc = 1'b0;
        val = v; rice_k = K_W'(rk); exp_k = K_W'(ek); last_rice_q = LQ_W'(lq);
        is_ac = ac; is_minus_n = neg; in_valid = 1'b1;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sb.push_back(model(v, rk, ek, lq, ac, neg));
            end
            @(posedge clk); #1;
        end
        if (!acc) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: got in_ready=0 for 300 cycles expected acceptance");
        end
        in_valid = 1'b0;
        val = $urandom;
        rice_k = K_W'($urandom);
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d words outstanding expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; val = '0; rice_k = '0; exp_k = '0;
        last_rice_q = '0; is_ac = 1'b0; is_minus_n = 1'b0; out_ready = 1'b1; clr_total = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({out_valid, overflow, code_len, code_bits, total_bits} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b ovf=%b len=%0d bits=%h total=%0d expected all 0",
                     out_valid, overflow, code_len, code_bits, total_bits);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rice();
        int k;
        send(2, 0, 0, 3, 1'b0, 1'b0);
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        vectors++;
        if (k != 3) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles expected 3", k);
        end
        @(posedge clk); #1;
        drain();
        send(6, 2, 0, 4, 1'b1, 1'b1);
        send(13, 3, 1, 0, 1'b0, 1'b0);
        send(7, 3, 0, 0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_exp();
        send(5, 0, 0, 1, 1'b0, 1'b0);
        send(100, 2, 3, 2, 1'b1, 1'b1);
        send(40, 1, 2, 7, 1'b0, 1'b0);
        send(1000, 0, 7, 0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_backpressure();
        clr_total = 1'b1;
        @(posedge clk); #1 clr_total = 1'b0;
        fork
            begin
                for (int v = 0; v < 5; v++) send(VAL_W'(v), 0, 0, 7, 1'b0, 1'b0);
            end
            begin
                logic [CODE_W-1:0] sbits;
                logic [LEN_W-1:0]  slen;
                logic              sovf;
                logic [CNT_W-1:0]  stot;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    @(negedge clk);
                    vectors++;
                    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                        miscompares++;
                        $display("FAIL stall_flags: got out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
                    end
                    if (s == 0) begin
                        sbits = code_bits; slen = code_len; sovf = overflow; stot = total_bits;
                    end else begin
                        vectors++;
                        if (code_bits !== sbits || code_len !== slen || overflow !== sovf || total_bits !== stot) begin
                            miscompares++;
                            $display("FAIL stall_hold: got bits=%h len=%0d total=%0d expected bits=%h len=%0d total=%0d",
                                     code_bits, code_len, total_bits, sbits, slen, stot);
                        end
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        @(negedge clk);
        vectors++;
        if (total_bits !== CNT_W'(15)) begin
            miscompares++;
            $display("FAIL total_stream: got %0d expected 15", total_bits);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        send('1, 0, 0, 7, 1'b1, 1'b0);
        send(0, 0, 0, 7, 1'b1, 1'b1);
        send(62, 0, 0, 7, 1'b1, 1'b0);
        send(63, 0, 0, 7, 1'b0, 1'b0);
        send(64, 0, 0, 7, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [VAL_W-1:0] v;
                    v = ($urandom_range(0, 3) == 0) ? VAL_W'($urandom) : VAL_W'($urandom_range(0, 200));
                    send(v, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_flush();
        bit seen = 1'b0;
        out_ready = 1'b0;
        send(1, 0, 0, 7, 1'b0, 1'b0);
        send(2, 0, 0, 7, 1'b0, 1'b0);
        send(3, 0, 0, 7, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_setup: got out_valid=%b expected 1", out_valid);
        end
        @(posedge clk); #1 reset_n = 1'b0;
        sb.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen || total_bits !== '0) begin
            miscompares++;
            $display("FAIL flush: got out_valid_seen=%b total=%0d expected 0 0", seen, total_bits);
        end
        @(posedge clk); #1;
        send(6, 2, 0, 4, 1'b1, 1'b1);
        drain();
        @(negedge clk);
        vectors++;
        if (total_bits !== CNT_W'(5)) begin
            miscompares++;
            $display("FAIL total_pre_clear: got %0d expected 5", total_bits);
        end
        @(posedge clk); #1;
        send(2, 0, 0, 3, 1'b0, 1'b0);
        begin
            bit got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (out_valid) got = 1'b1;
            end
            vectors++;
            if (!got) begin
                miscompares++;
                $display("FAIL clr_wait: got no out_valid in 20 cycles expected one");
            end
        end
        clr_total = 1'b1;
        @(posedge clk); #1 clr_total = 1'b0;
        @(negedge clk);
        vectors++;
        if (total_bits !== CNT_W'(3)) begin
            miscompares++;
            $display("FAIL clr_with_handshake: got %0d expected 3", total_bits);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_rice();
        test_exp();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
